// File: rtl/axis_capture_readout.sv
// Readout sequencer for the axis_to_mem capture buffer: passes samples through while idle, then
// sweeps the frozen buffer oldest-first into one backpressured AXI-stream packet via a skid FIFO.
module axis_capture_readout #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig,
  output logic                  busy,
  output logic                  done,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  cap_tvalid,
  output logic [DATA_WIDTH-1:0] cap_tdata,
  output logic                  cap_tlast,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W      = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   last_addr_q;
  logic [READ_LATENCY-1:0] vld_sr_q;
  logic [READ_LATENCY-1:0] tag_sr_q;
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_tag_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        fifo_cnt_q;
  logic [CNT_W-1:0]        fifo_cnt_d;
  logic [CNT_W-1:0]        inflight_s;
  logic [SUM_W-1:0]        credit_sum_s;
  logic                    issue_s;
  logic                    last_issue_s;
  logic                    push_s;
  logic                    pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight_s = {CNT_W{1'b0}};
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_W'(vld_sr_q[i]);
    end
  end

  // Reads in flight plus buffered beats never exceed the FIFO depth, so a push always has room.
  assign credit_sum_s = SUM_W'(inflight_s) + SUM_W'(fifo_cnt_q);
  assign issue_s      = (state_q == ST_READ) && (credit_sum_s < SUM_W'(FIFO_DEPTH));
  assign last_issue_s = issue_s && (cnt_q == LAST_ADDR);
  assign push_s       = vld_sr_q[READ_LATENCY-1];
  assign pop_s        = m_axis_tvalid && m_axis_tready;

  assign mem_addr      = issue_s ? cnt_q : last_addr_q;
  assign m_axis_tvalid = (fifo_cnt_q != {CNT_W{1'b0}});
  assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
  assign m_axis_tlast  = m_axis_tvalid && fifo_tag_q[rd_ptr_q];
  assign done          = pop_s && m_axis_tlast && (state_q == ST_DRAIN);
  assign busy          = (state_q != ST_IDLE);

  assign s_axis_tready = (state_q == ST_IDLE);
  assign cap_tvalid    = (state_q == ST_IDLE) && s_axis_tvalid;
  assign cap_tlast     = (state_q == ST_IDLE) && s_axis_tlast;
  assign cap_tdata     = s_axis_tdata;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push_s && !pop_s) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end else begin
      fifo_cnt_d = fifo_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {ADDR_WIDTH{1'b0}};
      last_addr_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q <= ST_READ;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
          end
        end
        ST_READ: begin
          if (issue_s) begin
            cnt_q       <= cnt_q + ADDR_WIDTH'(1);
            last_addr_q <= cnt_q;
            if (last_issue_s) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The tag rides alongside each read so the last entry is marked when its data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= {READ_LATENCY{1'b0}};
      tag_sr_q   <= {READ_LATENCY{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      fifo_cnt_q <= {CNT_W{1'b0}};
      fifo_tag_q <= {FIFO_DEPTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      vld_sr_q[0] <= issue_s;
      tag_sr_q[0] <= last_issue_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
        tag_sr_q[i] <= tag_sr_q[i-1];
      end
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= mem_dout;
        fifo_tag_q[wr_ptr_q]  <= tag_sr_q[READ_LATENCY-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push_s && !pop_s && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_axis_capture_readout.sv
// Bench for axis_capture_readout: a circular capture-buffer model feeds the read port, and a
// sample-history queue predicts each readout packet independently of the buffer model.
module tb_axis_capture_readout;
  localparam int D   = 32;
  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int AW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic          busy;
  logic          done;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          cap_tvalid;
  logic [W-1:0]  cap_tdata;
  logic          cap_tlast;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_dout;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;

  axis_capture_readout #(
    .MEMORY_DEPTH(D), .DATA_WIDTH(W), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .busy(busy), .done(done),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .cap_tvalid(cap_tvalid), .cap_tdata(cap_tdata),
    .cap_tlast(cap_tlast), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast)
  );

  // Capture buffer: circular, restarts empty on the first write after a tlast beat.
  logic [W-1:0] bmem [D] = '{default: '0};
  logic [W-1:0] rpipe [LAT] = '{default: '0};
  int           bwp = 0;
  logic         bfresh = 1'b0;

  always @(posedge clk) begin
    if (cap_tvalid) begin
      if (bfresh) begin
        for (int i = 0; i < D; i++) bmem[i] <= '0;
        bmem[0] <= cap_tdata;
        bwp <= 1;
      end else begin
        bmem[bwp] <= cap_tdata;
        bwp <= (bwp + 1) % D;
      end
      bfresh <= cap_tlast;
    end
    rpipe[0] <= bmem[(bwp + int'(mem_addr)) % D];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_dout = rpipe[LAT-1];

  typedef struct {
    bit tlast_first;
    int n_samples;
    int base;
    int ready_pct;
    bit stream;
    int retrig_beat;
    int rst_beat;
    int exp_pkts;
    int exp_dones;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int beat = 0;
  int dones = 0;
  int pkts = 0;
  bit exp_busy = 1'b0;
  bit timing_on = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic [W-1:0] hist[$];
  bit hfresh = 1'b0;
  logic [W-1:0] exp_pkt [D];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the reference model, return after the rise.
  task automatic tick();
    bit last_acc;
    last_acc = 1'b0;
    @(negedge clk);
    cyc++;
    chk("busy", busy, exp_busy);
    chk("s_tready", s_tready, !exp_busy);
    chk("cap_tvalid", cap_tvalid, s_tvalid && !exp_busy);
    chk("cap_tlast", cap_tlast, s_tlast && !exp_busy);
    if (!exp_busy) begin
      chk("cap_tdata", cap_tdata, s_tdata);
      chk("m_tvalid_idle", m_tvalid, 1'b0);
    end
    if (prev_stall) begin
      chk("stall_valid", m_tvalid, 1'b1);
      chk("stall_data", m_tdata, prev_data);
      chk("stall_last", m_tlast, prev_last);
    end
    if (exp_busy && m_tvalid && m_tready) begin
      chk("tdata", m_tdata, exp_pkt[beat]);
      chk("tlast", m_tlast, beat == D - 1);
      chk("done", done, beat == D - 1);
      if (timing_on) chk("beat_cycle", cyc - trig_cyc, 2 + LAT + beat);
      last_acc = (beat == D - 1);
      beat++;
    end else begin
      chk("done_quiet", done, 1'b0);
    end
    if (done) dones++;
    if (last_acc) pkts++;
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_data = m_tdata;
    prev_last = m_tlast;
    if (s_tvalid && !exp_busy) begin
      if (hfresh) hist.delete();
      hist.push_back(s_tdata);
      hfresh = s_tlast;
    end
    if (rst) begin
      exp_busy = 1'b0;
      beat = 0;
      prev_stall = 1'b0;
    end else if (!exp_busy && trig) begin
      exp_busy = 1'b1;
      beat = 0;
      trig_cyc = cyc;
      for (int i = 0; i < D; i++) begin
        int idx;
        idx = hist.size() - D + i;
        exp_pkt[i] = (idx < 0) ? '0 : hist[idx];
      end
    end else if (last_acc) begin
      exp_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int guard;
    int pk0;
    int dn0;
    bit fired_rt;
    bit fired_rst;
    pk0 = pkts;
    dn0 = dones;
    fired_rt = 1'b0;
    fired_rst = 1'b0;
    m_tready = 1'b1;
    if (v.tlast_first) begin
      s_tvalid = 1'b1; s_tdata = 32'd999; s_tlast = 1'b1;
      tick();
      s_tlast = 1'b0;
    end
    for (int i = 0; i < v.n_samples; i++) begin
      s_tvalid = 1'b1; s_tdata = W'(v.base + i);
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    timing_on = (v.ready_pct == 100);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1 && !fired_rst) break;
      s_tvalid = v.stream; s_tdata = $urandom; trig = 1'b1;
      tick();
      trig = 1'b0;
      guard = 0;
      while (exp_busy && guard < 2000) begin
        m_tready = ($urandom_range(99) < v.ready_pct);
        s_tvalid = v.stream;
        s_tdata = $urandom;
        s_tlast = v.stream && ($urandom_range(7) == 0);
        trig = !fired_rt && v.retrig_beat >= 0 && beat >= v.retrig_beat;
        if (trig) fired_rt = 1'b1;
        rst = pass == 0 && !fired_rst && v.rst_beat >= 0 && beat >= v.rst_beat;
        if (rst) fired_rst = 1'b1;
        tick();
        guard++;
      end
      trig = 1'b0;
      rst = 1'b0;
      chk("timeout", guard < 2000, 1'b1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    chk("packets", pkts - pk0, v.exp_pkts);
    chk("dones", dones - dn0, v.exp_dones);
  endtask

  vec_t vecs [7];

  initial begin
    //             tlast1 n   base ready strm retrig rst pkts dones
    vecs[0] = '{1'b0, 40,   0, 100, 1'b0, -1, -1, 1, 1};
    vecs[1] = '{1'b1,  5, 100, 100, 1'b0, -1, -1, 1, 1};
    vecs[2] = '{1'b0, 50, 200,  30, 1'b0, -1, -1, 1, 1};
    vecs[3] = '{1'b0, 10, 300,  70, 1'b1, -1, -1, 1, 1};
    vecs[4] = '{1'b0, 20, 400, 100, 1'b0, -1, 10, 1, 1};
    vecs[5] = '{1'b0,  8, 500,  60, 1'b0,  5, -1, 1, 1};
    vecs[6] = '{1'b1, 12, 600,  10, 1'b1, -1, -1, 1, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_tdata", m_tdata, '0);
    chk("rst_mem_addr", mem_addr, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // trig and rst together: reset must win and the block stays idle
    rst = 1'b1; trig = 1'b1;
    tick();
    rst = 1'b0; trig = 1'b0;
    tick();
    chk("trig_rst_mem_addr", mem_addr, '0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
